if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched {instruction, pc_current, pc_next} tuples with a valid/ready handshake on both sides.
- Drives a stall back to fetch when full and discards all contents on a branch/jump flush.
- Decouples fetch from decode back-pressure without losing or duplicating instructions.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- WIDTH, 32, width of the instruction and of each PC field.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid tuple this cycle.
- in_instruction  input  WIDTH  fetched instruction word.
- in_pc_current  input  WIDTH  address of the fetched instruction.
- in_pc_next  input  WIDTH  pc_current + 4 from fetch.
- in_ready  output  1  queue can accept a tuple this cycle.
- fetch_stall  output  1  freeze fetch PC; equals ~in_ready.
- flush  input  1  discard all entries (taken branch/jump from a later stage).
- out_valid  output  1  head entry present.
- out_instruction  output  WIDTH  head instruction; 0 when empty.
- out_pc_current  output  WIDTH  head pc_current; 0 when empty.
- out_pc_next  output  WIDTH  head pc_next; 0 when empty.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high: reset port samples on the rising edge of clk, no asynchronous path.
- Reset: wr_ptr=0, rd_ptr=0, count=0. Therefore out_valid=0, out_* = 0, in_ready=1, fetch_stall=0. Storage array is not cleared.
- Push: occurs when in_valid && in_ready. Writes the tuple at wr_ptr, then wr_ptr += 1 mod DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr += 1 mod DEPTH.
- in_ready = (count != DEPTH). There is no full-with-pop bypass, so in_ready never depends combinationally on out_ready.
- out_valid = (count != 0). out_* = storage[rd_ptr] when out_valid, else 0. Outputs are driven from registered storage with a mux only; there is no in-to-out combinational path.
- Latency: a tuple pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no bypass while empty.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, both pointers advance.
- Full (count==DEPTH): in_ready=0 and in_valid is ignored. A pop while full returns in_ready=1 in the next cycle.
- Empty (count==0): out_ready is ignored and pointers hold.
- Pointer wrap-around: both pointers use natural modulo-DEPTH wrap. FIFO ordering must hold across the wrap.
- Flush: synchronous, same effect as reset on pointers and count.
  - A push or pop in the flush cycle is discarded.
  - Next cycle: count=0, out_valid=0.
- Priority: reset > flush > push/pop.
- Reset or flush mid-stream: no partially-consumed state remains; the first push afterwards lands at entry 0.
- Assertions for the bench:
  - count never exceeds DEPTH.
  - No push accepted while count==DEPTH.
  - No pop while count==0.

Decomposition:
- Shared pipeline package:
  - WIDTH default (32).
  - Packed if_id_entry_t struct {instruction, pc_current, pc_next}.
  - INSTR_NOP constant (0), reused by decode for bubbles.
- No sub-module needed. Storage, pointers and count live in one module; the storage array is of if_id_entry_t.

Test Plan:
- Reset: assert reset 2 cycles, then release → count=0, out_valid=0, out_instruction=0, in_ready=1, fetch_stall=0.
- Single pass-through: push {0x00A00093, 0x0, 0x4} with out_ready=1 → out_valid=1 next cycle with those values; count returns to 0 the cycle after.
- Fill and stall: out_ready=0, push pcs 0x0,0x4,0x8,0xC, attempt 0x10 → count=4, fetch_stall=1, and 0x10 is not stored. Pop once → in_ready=1 next cycle. The 0x10 retry is accepted and drains last.
- Wrap-around ordering: 10 pushes (pcs 0x0..0x24) with out_ready toggling every cycle → decode sees exactly 0x0,0x4,…,0x24 in order, no gaps or duplicates.
- Simultaneous push/pop at count=2 → count stays 2; the head advances to the second entry and the new tuple is appended.
- Flush with 3 entries plus a concurrent push of 0x30 → next cycle count=0, out_valid=0. The next push of 0x40 appears at the head with pc_next=0x44.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode pipeline types: the IF/ID tuple layout and the decode bubble word.
package if_id_queue_pkg;

    localparam int unsigned IF_ID_WIDTH = 32;

    typedef struct packed {
        logic [IF_ID_WIDTH-1:0] instruction;
        logic [IF_ID_WIDTH-1:0] pc_current;
        logic [IF_ID_WIDTH-1:0] pc_next;
    } if_id_entry_t;

    localparam logic [IF_ID_WIDTH-1:0] INSTR_NOP = '0;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of IF/ID tuples with valid/ready on
// both sides, a fetch stall when full and a synchronous flush for taken branches/jumps.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = IF_ID_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_instruction,
    input  logic [WIDTH-1:0]         in_pc_current,
    input  logic [WIDTH-1:0]         in_pc_next,
    output logic                     in_ready,
    output logic                     fetch_stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_instruction,
    output logic [WIDTH-1:0]         out_pc_current,
    output logic [WIDTH-1:0]         out_pc_next,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    if_id_entry_t mem_q [DEPTH];
    if_id_entry_t in_entry;
    if_id_entry_t head;

    // Readiness depends only on registered occupancy, never on out_ready.
    assign in_ready    = (count_q != FULL_COUNT);
    assign fetch_stall = ~in_ready;
    assign out_valid   = (count_q != '0);
    assign count       = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign in_entry = '{
        instruction: in_instruction,
        pc_current:  in_pc_current,
        pc_next:     in_pc_next
    };

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        out_instruction = INSTR_NOP;
        out_pc_current  = '0;
        out_pc_next     = '0;
        if (out_valid) begin
            out_instruction = head.instruction;
            out_pc_current  = head.pc_current;
            out_pc_next     = head.pc_next;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; a write in a flush or reset cycle is simply dropped.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

endmodule
